rtc_ad_bus_ctrl: RTL and testbench

RTC_AD_BUS_CTRL -- requirements
Module: rtc_ad_bus_ctrl

---
 rtl/rtc_bus_pkg.sv | 40 ++++
 rtl/rtc_bus_timer.sv | 26 ++
 rtl/rtc_ad_bus_ctrl.sv | 174 +++++++++++++++++
 tb/tb_rtc_ad_bus_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC address/data multiplexed bus controller.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_CS  = 3'd1,
    ADDR_WR  = 3'd2,
    ADDR_REL = 3'd3,
    DATA_CS  = 3'd4,
    DATA_STB = 3'd5,
    DATA_REL = 3'd6,
    DONE     = 3'd7
  } rtc_state_t;

  localparam int unsigned T_PULSE_DEF = 4;
  localparam int unsigned T_GAP_DEF   = 2;

  // RTC register map used by the requesters
  localparam logic [7:0] RTC_REG_STATUS  = 8'h00;
  localparam logic [7:0] RTC_REG_CTRL    = 8'h02;
  localparam logic [7:0] RTC_REG_INIT    = 8'h10;
  localparam logic [7:0] RTC_REG_SEG     = 8'h21;
  localparam logic [7:0] RTC_REG_MIN     = 8'h22;
  localparam logic [7:0] RTC_REG_HORA    = 8'h23;
  localparam logic [7:0] RTC_REG_DIA     = 8'h24;
  localparam logic [7:0] RTC_REG_MES     = 8'h25;
  localparam logic [7:0] RTC_REG_ANIO    = 8'h26;
  localparam logic [7:0] RTC_REG_DSEM    = 8'h27;
  localparam logic [7:0] RTC_REG_T_SEG   = 8'h41;
  localparam logic [7:0] RTC_REG_T_MIN   = 8'h42;
  localparam logic [7:0] RTC_REG_T_HORA  = 8'h43;
  localparam logic [7:0] RTC_REG_CMD_TX0 = 8'hF0;
  localparam logic [7:0] RTC_REG_CMD_TX1 = 8'hF1;
  localparam logic [7:0] RTC_REG_CMD_TX2 = 8'hF2;

  function automatic logic bcd_invalid(input logic [7:0] v);
    return (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Phase down-counter: load a value, count down to zero, flag zero.
module rtc_bus_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (dec && (cnt_q != '0))
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rtc_ad_bus_ctrl.sv
// Multiplexed address/data RTC bus controller with registered strobes.
// Optional read-data BCD check enabled by defining RTC_BCD_CHECK_EN.
//
// Handshake: a request is taken when in_en_funcion_rtc=1 in IDLE; inputs are
// latched in that cycle and ignored until out_flag_done pulses one cycle later
// than the final release gap. The requester has no ready signal to watch.
module rtc_ad_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_en_funcion_rtc,
  input  logic       in_funcion_w_r,
  input  logic [7:0] in_addr_ram_rtc,
  input  logic       in_flag_inicio,
  input  logic [7:0] in_dato_inicio,
  input  logic [7:0] in_dato_usuario,
  output logic       out_flag_done,
  output logic [7:0] out_dato_leido,
  output logic       out_dato_valid,
  output logic       out_cs_n,
  output logic       out_rd_n,
  output logic       out_wr_n,
  output logic       out_ad,
  output logic [7:0] out_bus_dato,
  output logic       out_bus_oe,
  input  logic [7:0] in_bus_dato,
`ifdef RTC_BCD_CHECK_EN
  output logic       out_error_bcd,
`endif
  output rtc_state_t dbg_state
);

  localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
  localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);

  rtc_state_t state_q, state_d;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [3:0] tmr_val;

  logic       accept;
  logic [7:0] addr_q, addr_d, data_q, data_d;
  logic       wr_q, wr_d;

  logic       cs_d, rd_d, wrs_d, ad_d, oe_d, done_d, valid_d;
  logic [7:0] bus_d;

  rtc_bus_timer #(.W(4)) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE:     if (in_en_funcion_rtc) state_d = ADDR_CS;
      ADDR_CS:  begin state_d = ADDR_WR; tmr_load = 1'b1; tmr_val = PULSE_LD; end
      ADDR_WR:  if (tmr_zero) begin state_d = ADDR_REL; tmr_load = 1'b1; tmr_val = GAP_LD; end
                else tmr_dec = 1'b1;
      ADDR_REL: if (tmr_zero) state_d = DATA_CS; else tmr_dec = 1'b1;
      DATA_CS:  begin state_d = DATA_STB; tmr_load = 1'b1; tmr_val = PULSE_LD; end
      DATA_STB: if (tmr_zero) begin state_d = DATA_REL; tmr_load = 1'b1; tmr_val = GAP_LD; end
                else tmr_dec = 1'b1;
      DATA_REL: if (tmr_zero) state_d = DONE; else tmr_dec = 1'b1;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Next-cycle request fields so the strobes can be registered from state_d
  assign accept = (state_q == IDLE) && in_en_funcion_rtc;
  assign addr_d = accept ? in_addr_ram_rtc : addr_q;
  assign wr_d   = accept ? in_funcion_w_r  : wr_q;
  assign data_d = accept ? (in_flag_inicio ? in_dato_inicio : in_dato_usuario) : data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
    end
  end

  always_comb begin
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wrs_d   = 1'b1;
    ad_d    = 1'b1;
    oe_d    = 1'b0;
    bus_d   = '0;
    done_d  = 1'b0;
    valid_d = 1'b0;
    case (state_d)
      ADDR_CS:  begin cs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; bus_d = addr_d; end
      ADDR_WR:  begin cs_d = 1'b0; wrs_d = 1'b0; ad_d = 1'b0; oe_d = 1'b1; bus_d = addr_d; end
      ADDR_REL: ad_d = 1'b0;
      DATA_CS:  begin
        cs_d = 1'b0;
        oe_d = wr_d;
        if (wr_d) bus_d = data_d;
      end
      DATA_STB: begin
        cs_d = 1'b0;
        if (wr_d) begin wrs_d = 1'b0; oe_d = 1'b1; bus_d = data_d; end
        else      rd_d = 1'b0;
      end
      DONE:     begin done_d = 1'b1; valid_d = !wr_d; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_cs_n       <= 1'b1;
      out_rd_n       <= 1'b1;
      out_wr_n       <= 1'b1;
      out_ad         <= 1'b1;
      out_bus_oe     <= 1'b0;
      out_bus_dato   <= '0;
      out_flag_done  <= 1'b0;
      out_dato_valid <= 1'b0;
    end else begin
      out_cs_n       <= cs_d;
      out_rd_n       <= rd_d;
      out_wr_n       <= wrs_d;
      out_ad         <= ad_d;
      out_bus_oe     <= oe_d;
      out_bus_dato   <= bus_d;
      out_flag_done  <= done_d;
      out_dato_valid <= valid_d;
    end
  end

  // Sample the pins at the end of the last read strobe cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_dato_leido <= '0;
    else if ((state_q == DATA_STB) && tmr_zero && !wr_q)
      out_dato_leido <= in_bus_dato;
  end

`ifdef RTC_BCD_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      out_error_bcd <= 1'b0;
    else
      out_error_bcd <= (state_d == DONE) && !wr_d && bcd_invalid(out_dato_leido);
  end
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rtc_ad_bus_ctrl.sv
// Self-checking bench for rtc_ad_bus_ctrl: vector table, done scoreboard, corner sequences.
module tb_rtc_ad_bus_ctrl;
  import rtc_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_en_funcion_rtc, in_funcion_w_r, in_flag_inicio;
  logic [7:0] in_addr_ram_rtc, in_dato_inicio, in_dato_usuario, in_bus_dato;
  logic       out_flag_done, out_dato_valid, out_cs_n, out_rd_n, out_wr_n, out_ad, out_bus_oe;
  logic [7:0] out_dato_leido, out_bus_dato;
  rtc_state_t dbg_state;
`ifdef RTC_BCD_CHECK_EN
  logic       out_error_bcd;
`endif

  rtc_ad_bus_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .in_en_funcion_rtc (in_en_funcion_rtc),
    .in_funcion_w_r    (in_funcion_w_r),
    .in_addr_ram_rtc   (in_addr_ram_rtc),
    .in_flag_inicio    (in_flag_inicio),
    .in_dato_inicio    (in_dato_inicio),
    .in_dato_usuario   (in_dato_usuario),
    .out_flag_done     (out_flag_done),
    .out_dato_leido    (out_dato_leido),
    .out_dato_valid    (out_dato_valid),
    .out_cs_n          (out_cs_n),
    .out_rd_n          (out_rd_n),
    .out_wr_n          (out_wr_n),
    .out_ad            (out_ad),
    .out_bus_dato      (out_bus_dato),
    .out_bus_oe        (out_bus_oe),
    .in_bus_dato       (in_bus_dato),
`ifdef RTC_BCD_CHECK_EN
    .out_error_bcd     (out_error_bcd),
`endif
    .dbg_state         (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic       w_r;
    logic [7:0] addr;
    logic       flag;
    logic [7:0] ini;
    logic [7:0] usr;
    logic [7:0] bus_rd;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs[NVEC];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int viol  = 0;
  int done_seen = 0;
  logic [7:0] last_rd = 8'h00;

  // {done cycle, is_read, read data}
  logic [40:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bad_nibble(input logic [7:0] v);
    return (v[7:4] >= 4'hA) || (v[3:0] >= 4'hA);
  endfunction

  task automatic monitor();
    logic [40:0] e;
    if (!reset) return;
    if (!out_wr_n && !out_rd_n) viol++;
    if ((!out_wr_n || !out_rd_n) && out_cs_n) viol++;
    if (!out_rd_n && out_bus_oe) viol++;
    if (out_flag_done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, int'(e[40:9]));
        check("dato_valid", int'(out_dato_valid), int'(e[8]));
        if (e[8]) check("dato_leido", int'(out_dato_leido), int'(e[7:0]));
`ifdef RTC_BCD_CHECK_EN
        check("error_bcd", int'(out_error_bcd), int'(e[8] && bad_nibble(e[7:0])));
`endif
      end
    end else begin
      if (out_dato_valid) viol++;
`ifdef RTC_BCD_CHECK_EN
      if (out_error_bcd) viol++;
`endif
    end
  endtask

  // one clock: advance to the next falling edge and observe
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input vec_t v);
    in_en_funcion_rtc = 1'b1;
    in_funcion_w_r    = v.w_r;
    in_addr_ram_rtc   = v.addr;
    in_flag_inicio    = v.flag;
    in_dato_inicio    = v.ini;
    in_dato_usuario   = v.usr;
    in_bus_dato       = v.bus_rd;
  endtask

  task automatic run_vec(input vec_t v);
    int c0, a_cnt, w_cnt, r_cnt;
    c0 = cyc;
    a_cnt = 0; w_cnt = 0; r_cnt = 0;
    drive(v);
    exp_q.push_back({32'(c0 + 15), !v.w_r, v.bus_rd});
    if (!v.w_r) last_rd = v.bus_rd;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 1) begin
        in_en_funcion_rtc = 1'b0;
        in_funcion_w_r    = ~v.w_r;
        in_addr_ram_rtc   = ~v.addr;
        in_flag_inicio    = ~v.flag;
        in_dato_inicio    = ~v.ini;
        in_dato_usuario   = ~v.usr;
      end
      if (!out_cs_n && !out_wr_n && !out_ad && out_bus_oe && out_bus_dato == v.addr) a_cnt++;
      if (!out_cs_n && !out_wr_n && out_ad && out_bus_oe && out_bus_dato == v.exp_data) w_cnt++;
      if (!out_cs_n && !out_rd_n && out_ad && !out_bus_oe) r_cnt++;
    end
    check("addr_wr_cycles", a_cnt, 4);
    check("data_wr_cycles", w_cnt, v.w_r ? 4 : 0);
    check("data_rd_cycles", r_cnt, v.w_r ? 0 : 4);
    check("leido_hold", int'(out_dato_leido), int'(last_rd));
    tick();
  endtask

  initial begin : main
    int c0, g1, g2;
    vec_t v;

    vecs[0]  = '{1'b1, 8'h21, 1'b0, 8'h99, 8'h45, 8'h00, 8'h45};
    vecs[1]  = '{1'b0, 8'h43, 1'b0, 8'h00, 8'h00, 8'h59, 8'h00};
    vecs[2]  = '{1'b1, 8'h02, 1'b1, 8'h10, 8'hEE, 8'h00, 8'h10};
    vecs[3]  = '{1'b0, 8'h27, 1'b1, 8'h55, 8'h66, 8'h12, 8'h00};
    vecs[4]  = '{1'b1, 8'hF0, 1'b1, 8'hA5, 8'h5A, 8'hFF, 8'hA5};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 8'h41, 1'b0, 8'h00, 8'h00, 8'h3A, 8'h00};
    for (int i = 7; i < NVEC; i++) begin
      vecs[i].w_r    = 1'($urandom_range(0, 1));
      vecs[i].addr   = 8'($urandom_range(0, 255));
      vecs[i].flag   = 1'($urandom_range(0, 1));
      vecs[i].ini    = 8'($urandom_range(0, 255));
      vecs[i].usr    = 8'($urandom_range(0, 255));
      vecs[i].bus_rd = 8'($urandom_range(0, 255));
      vecs[i].exp_data = vecs[i].flag ? vecs[i].ini : vecs[i].usr;
    end

    reset = 1'b0;
    in_en_funcion_rtc = 1'b0;
    in_funcion_w_r = 1'b0;
    in_addr_ram_rtc = 8'h00;
    in_flag_inicio = 1'b0;
    in_dato_inicio = 8'h00;
    in_dato_usuario = 8'h00;
    in_bus_dato = 8'h00;

    // reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) in_en_funcion_rtc = 1'b1;
      check("reset_strobes", int'({out_cs_n, out_rd_n, out_wr_n, out_ad, out_bus_oe, out_flag_done, out_dato_valid}), 7'b1111000);
      check("reset_data", int'({out_bus_dato, out_dato_leido}), 0);
    end
    in_en_funcion_rtc = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_after_reset", int'(dbg_state), int'(IDLE));

    foreach (vecs[i]) run_vec(vecs[i]);

    // back-to-back: enable held, second request presented during the single IDLE cycle
    c0 = cyc;
    g1 = 0; g2 = 0;
    v = '{1'b1, 8'h02, 1'b1, 8'h10, 8'h77, 8'h00, 8'h10};
    drive(v);
    exp_q.push_back({32'(c0 + 15), 1'b0, 8'h00});
    exp_q.push_back({32'(c0 + 31), 1'b0, 8'h00});
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1) begin in_dato_inicio = 8'h00; in_dato_usuario = 8'h88; end
      if (k == 16) check("b2b_idle_gap", int'(dbg_state), int'(IDLE));
      if (k == 17) in_en_funcion_rtc = 1'b0;
      if (!out_wr_n && out_ad && out_bus_oe) begin
        if (k < 16 && out_bus_dato == 8'h10) g1++;
        if (k > 16 && out_bus_dato == 8'h00) g2++;
      end
    end
    check("b2b_first_data", g1, 4);
    check("b2b_second_data", g2, 4);

    // reset during the data strobe
    done_seen = 0;
    v = '{1'b1, 8'h22, 1'b0, 8'h00, 8'h33, 8'h00, 8'h33};
    drive(v);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) in_en_funcion_rtc = 1'b0;
    end
    check("pre_reset_wr_n", int'(out_wr_n), 0);
    #1 reset = 1'b0;
    #1;
    check("async_reset_strobes", int'({out_cs_n, out_wr_n, out_bus_oe, out_flag_done}), 4'b1100);
    check("async_reset_state", int'(dbg_state), int'(IDLE));
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("no_done_after_abort", done_seen, 0);

    check("protocol_violations", viol, 0);
    check("pending_done", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
